// File: rtl/onchip_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter_if
// Single-beat Avalon-MM master bundle for one requester of the shared RAM port.
//   address       : word address (ADDR_W bits)
//   read / write  : request strobes; both high is treated as a write
//   writedata     : 128-bit write data
//   byteenable    : 16 byte lanes for writes
//   lock          : keep ownership after this transfer (lock builds only)
//   waitrequest   : high = request not accepted this cycle
//   readdata      : read data, qualified by readdatavalid
//   readdatavalid : one-cycle pulse with read data
// -----------------------------------------------------------------------------
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [127:0]      writedata;
   logic [15:0]       byteenable;
   logic              lock;
   logic              waitrequest;
   logic [127:0]      readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable, lock,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable, lock,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Round-robin arbiter letting two Avalon-MM masters (m0 = HPS bridge,
// m1 = LED pattern engine) share port s1 of the 64 x 128-bit on-chip RAM.
// One single-beat transfer is granted per cycle; read data comes back one
// cycle after acceptance with readdatavalid on the owning master only.
//
// Optional feature: define ONCHIP_MEM_ARB_LOCK_EN to honour mN.lock
// (bus locking with an idle timeout of LOCK_TIMEOUT cycles).
//
// Ports:
//   clk            : single clock, shared with the RAM
//   reset          : synchronous, active-high
//   m0, m1         : master bundles (onchip_mem_arbiter_if.slave)
//   mem_address    : RAM s1 address
//   mem_chipselect : high on any grant
//   mem_write      : high for a granted write
//   mem_writedata  : winner's write data
//   mem_byteenable : winner's byte lanes
//   mem_clken      : tied high
//   mem_readdata   : RAM s1 q, valid the cycle after the address
//
// Lock FSM states:
//   state    | meaning
//   ST_IDLE  | no lock held, plain round-robin
//   ST_LOCK0 | m0 owns the port, m1 stalled
//   ST_LOCK1 | m1 owns the port, m0 stalled
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
   parameter int unsigned LOCK_TIMEOUT = 16,
   parameter int          ADDR_W       = 6
) (
   input  logic                clk,
   input  logic                reset,
   onchip_mem_arbiter_if.slave m0,
   onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [127:0]        mem_writedata,
   output logic [15:0]         mem_byteenable,
   output logic                mem_clken,
   input  logic [127:0]        mem_readdata
);

   logic w_req0, w_req1;
   logic w_allow0, w_allow1;
   logic w_cand0, w_cand1;
   logic w_gnt0, w_gnt1;
   logic w_rd_gnt;

   logic r_last;    // index of the most recent winner
   logic r_rv;      // read issued last cycle
   logic r_owner;   // master that issued it

   assign w_req0 = m0.read | m0.write;
   assign w_req1 = m1.read | m1.write;

`ifdef ONCHIP_MEM_ARB_LOCK_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

   state_t           r_state, w_state_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   assign w_allow0 = (r_state != ST_LOCK1);
   assign w_allow1 = (r_state != ST_LOCK0);

   // The idle counter only advances while the owner is silent; any owner
   // request (granted or not) clears it.
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_nxt   = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_gnt0 && m0.lock)      w_state_nxt = ST_LOCK0;
            else if (w_gnt1 && m1.lock) w_state_nxt = ST_LOCK1;
         end
         ST_LOCK0: begin
            if (w_gnt0) begin
               if (!m0.lock) w_state_nxt = ST_IDLE;
            end else if (!w_req0) begin
               if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) w_state_nxt = ST_IDLE;
               else                                   w_tmo_nxt   = r_tmo + TMO_W'(1);
            end
         end
         ST_LOCK1: begin
            if (w_gnt1) begin
               if (!m1.lock) w_state_nxt = ST_IDLE;
            end else if (!w_req1) begin
               if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) w_state_nxt = ST_IDLE;
               else                                   w_tmo_nxt   = r_tmo + TMO_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end
`else
   logic w_unused_lock;

   assign w_allow0      = 1'b1;
   assign w_allow1      = 1'b1;
   assign w_unused_lock = ^{m0.lock, m1.lock, LOCK_TIMEOUT[0]};
`endif

   // No grants while reset is high, so the RAM sees no chipselect.
   assign w_cand0 = w_req0 & w_allow0 & ~reset;
   assign w_cand1 = w_req1 & w_allow1 & ~reset;

   // On contention the master that did not win last time goes first.
   assign w_gnt0 = w_cand0 & (~w_cand1 | r_last);
   assign w_gnt1 = w_cand1 & (~w_cand0 | ~r_last);

   assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
   assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

   assign mem_chipselect = w_gnt0 | w_gnt1;
   assign mem_write      = (w_gnt0 & m0.write) | (w_gnt1 & m1.write);
   assign mem_address    = w_gnt1 ? m1.address    : m0.address;
   assign mem_writedata  = w_gnt1 ? m1.writedata  : m0.writedata;
   assign mem_byteenable = w_gnt1 ? m1.byteenable : m0.byteenable;
   assign mem_clken      = 1'b1;

   // read+write together is a write, so it produces no return
   assign w_rd_gnt = (w_gnt0 & m0.read & ~m0.write) |
                     (w_gnt1 & m1.read & ~m1.write);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last  <= 1'b1;
         r_rv    <= 1'b0;
         r_owner <= 1'b0;
      end else begin
         if (mem_chipselect) r_last <= w_gnt1;
         r_rv <= w_rd_gnt;
         if (w_rd_gnt) r_owner <= w_gnt1;
      end
   end

   // Gating with reset kills a return that was in flight when reset arrived.
   assign m0.readdata      = mem_readdata;
   assign m1.readdata      = mem_readdata;
   assign m0.readdatavalid = r_rv & ~r_owner & ~reset;
   assign m1.readdatavalid = r_rv &  r_owner & ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Directed bench for onchip_mem_arbiter. Each step drives both masters for one
// cycle, checks waitrequest and the RAM-side drive against hand-written
// expectations, and queues the expected read data for every read it expects
// to be accepted. An independent monitor pops those queues whenever a
// readdatavalid pulse appears. A small RAM model sits on the mem_* port.
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;
   localparam int          ADDR_W       = 6;
   localparam int unsigned LOCK_TIMEOUT = 16;

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic         lk;
      logic [5:0]   a;
      logic [127:0] d;
      logic [15:0]  be;
   } req_t;

   localparam req_t         NOP = '0;
   localparam logic [127:0] Z   = '0;
   localparam logic [127:0] D_A = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] D_1 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] D_2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
   localparam logic [127:0] D_C = 128'hC0C0C0C0_13579BDF_2468ACE0_F0E1D2C3;
   localparam logic [127:0] D_5 = {16{8'h55}};
   localparam logic [127:0] D_AA = {16{8'hAA}};
   localparam logic [127:0] D_PART = {{12{8'h55}}, {4{8'hAA}}};

   logic clk = 1'b0;
   logic reset = 1'b1;

   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W)) u_m0 ();
   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W)) u_m1 ();

   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic [127:0]      mem_writedata;
   logic [15:0]       mem_byteenable;
   logic              mem_clken;
   logic [127:0]      mem_readdata;

   onchip_mem_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (u_m0),
      .m1             (u_m1),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   always #5 clk = ~clk;

   logic [127:0] ram [64];
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < 16; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
         mem_readdata <= ram[mem_address];
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [127:0] exp0 [$];
   logic [127:0] exp1 [$];
   logic [127:0] mon_e0, mon_e1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic req_t RD(input logic [5:0] a);
      req_t q = '0;
      q.rd = 1'b1;
      q.a  = a;
      return q;
   endfunction

   function automatic req_t WR(input logic [5:0] a, input logic [127:0] d,
                               input logic [15:0] be, input logic lk);
      req_t q = '0;
      q.wr = 1'b1;
      q.a  = a;
      q.d  = d;
      q.be = be;
      q.lk = lk;
      return q;
   endfunction

   task automatic apply(input req_t q0, input req_t q1);
      u_m0.read = q0.rd;  u_m0.write = q0.wr;  u_m0.lock = q0.lk;
      u_m0.address = q0.a; u_m0.writedata = q0.d; u_m0.byteenable = q0.be;
      u_m1.read = q1.rd;  u_m1.write = q1.wr;  u_m1.lock = q1.lk;
      u_m1.address = q1.a; u_m1.writedata = q1.d; u_m1.byteenable = q1.be;
   endtask

   // One bus cycle: drive, then check at the falling edge.
   task automatic step(input logic rs, input req_t q0, input req_t q1,
                       input logic ew0, input logic ew1, input logic [1:0] push,
                       input logic [127:0] x0, input logic [127:0] x1);
      logic acc0, acc1;
      req_t win;
      @(posedge clk);
      #2;
      reset = rs;
      apply(q0, q1);
      @(negedge clk);
      chk("m0_waitrequest", u_m0.waitrequest, ew0);
      chk("m1_waitrequest", u_m1.waitrequest, ew1);
      acc0 = (q0.rd | q0.wr) & ~ew0;
      acc1 = (q1.rd | q1.wr) & ~ew1;
      chk("mem_chipselect", mem_chipselect, acc0 | acc1);
      if (acc0 | acc1) begin
         win = acc1 ? q1 : q0;
         chk("mem_address", mem_address, win.a);
         chk("mem_write", mem_write, win.wr);
         if (win.wr) begin
            chk("mem_writedata", mem_writedata, win.d);
            chk("mem_byteenable", mem_byteenable, win.be);
         end
      end else begin
         chk("mem_write_idle", mem_write, 1'b0);
      end
      if (acc0 && q0.rd && !q0.wr && push[0]) exp0.push_back(x0);
      if (acc1 && q1.rd && !q1.wr && push[1]) exp1.push_back(x1);
   endtask

   always @(negedge clk) begin
      if (u_m0.readdatavalid === 1'b1) begin
         if (exp0.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL m0_readdatavalid: got unexpected pulse, expected none at %0t", $time);
         end else begin
            mon_e0 = exp0.pop_front();
            chk("m0_readdata", u_m0.readdata, mon_e0);
         end
      end
      if (u_m1.readdatavalid === 1'b1) begin
         if (exp1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL m1_readdatavalid: got unexpected pulse, expected none at %0t", $time);
         end else begin
            mon_e1 = exp1.pop_front();
            chk("m1_readdata", u_m1.readdata, mon_e1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      apply(NOP, NOP);

      // reset: requests are held off, no RAM access
      step(1'b1, RD(6'd5), NOP, 1'b1, 1'b1, 2'b00, Z, Z);
      step(1'b1, NOP, NOP, 1'b1, 1'b1, 2'b00, Z, Z);

      // m0 write then read back
      step(1'b0, WR(6'd5, D_A, 16'hFFFF, 1'b0), NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b0, RD(6'd5), NOP, 1'b0, 1'b0, 2'b01, D_A, Z);
      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);

      // contended writes: last winner was m0, so m1 goes first
      step(1'b0, WR(6'd1, D_1, 16'hFFFF, 1'b0), WR(6'd2, D_2, 16'hFFFF, 1'b0),
           1'b1, 1'b0, 2'b00, Z, Z);
      step(1'b0, WR(6'd1, D_1, 16'hFFFF, 1'b0), NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      // make m1 the last winner so m0 leads the read contention
      step(1'b0, NOP, RD(6'd2), 1'b0, 1'b0, 2'b10, Z, D_2);

      // continuous reads from both: m0, m1, m0, ...
      for (int i = 0; i < 8; i++)
         step(1'b0, RD(6'd1), RD(6'd2), (i % 2) == 1, (i % 2) == 0, 2'b11, D_1, D_2);
      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);

      // partial write
      step(1'b0, NOP, WR(6'd10, D_5, 16'hFFFF, 1'b0), 1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b0, NOP, WR(6'd10, D_AA, 16'h000F, 1'b0), 1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b0, NOP, RD(6'd10), 1'b0, 1'b0, 2'b10, Z, D_PART);

      // read and write together act as a write with no return
      step(1'b0, '{rd: 1'b1, wr: 1'b1, lk: 1'b0, a: 6'd20, d: D_C, be: 16'hFFFF}, NOP,
           1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b0, RD(6'd20), NOP, 1'b0, 1'b0, 2'b01, D_C, Z);
      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);

      // reset right after a granted read: the return must vanish
      step(1'b0, RD(6'd5), NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b1, NOP, NOP, 1'b1, 1'b1, 2'b00, Z, Z);
      step(1'b1, RD(6'd1), RD(6'd2), 1'b1, 1'b1, 2'b00, Z, Z);
      step(1'b0, RD(6'd1), RD(6'd2), 1'b0, 1'b1, 2'b11, D_1, D_2);
      step(1'b0, NOP, RD(6'd2), 1'b0, 1'b0, 2'b10, Z, D_2);
      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);

`ifdef ONCHIP_MEM_ARB_LOCK_EN
      // m1 locks; m0 stalled until m1 releases
      step(1'b0, NOP, WR(6'd30, D_C, 16'hFFFF, 1'b1), 1'b0, 1'b0, 2'b00, Z, Z);
      for (int i = 0; i < 3; i++)
         step(1'b0, RD(6'd1), NOP, 1'b1, 1'b0, 2'b00, Z, Z);
      step(1'b0, RD(6'd1), WR(6'd31, D_C, 16'hFFFF, 1'b0), 1'b1, 1'b0, 2'b00, Z, Z);
      step(1'b0, RD(6'd1), NOP, 1'b0, 1'b0, 2'b01, D_1, Z);

      // m0 locks then goes silent; m1 waits exactly LOCK_TIMEOUT cycles
      step(1'b0, WR(6'd32, D_C, 16'hFFFF, 1'b1), NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      for (int i = 0; i < int'(LOCK_TIMEOUT); i++)
         step(1'b0, NOP, RD(6'd2), 1'b0, 1'b1, 2'b00, Z, Z);
      step(1'b0, NOP, RD(6'd2), 1'b0, 1'b0, 2'b10, Z, D_2);
`endif

      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      step(1'b0, NOP, NOP, 1'b0, 1'b0, 2'b00, Z, Z);
      chk("m0_returns_missing", 128'(exp0.size()), Z);
      chk("m1_returns_missing", 128'(exp1.size()), Z);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
